// File: rtl/gate_seq_pkg.sv
// Shared types, constants and sizing helpers for the gate truth-table sequencer.
package gate_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  function automatic int nvec(input int n_in);
    return 32'sd1 << n_in;
  endfunction

  // Counter must hold SETTLE itself, and is never narrower than one bit.
  function automatic int cnt_w(input int settle);
    return (settle < 32'sd1) ? 32'sd1 : $clog2(settle + 32'sd1);
  endfunction

  localparam int N_IN_DEF   = 2;
  localparam int SETTLE_DEF = 1;
  localparam int NVEC       = nvec(N_IN_DEF);
  localparam int CNT_W      = cnt_w(SETTLE_DEF);

  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_XOR2  = 4'b0110;
  localparam logic [3:0] TT_NAND2 = 4'b0111;

endpackage

// File: rtl/gate_tt_sequencer_settle_timer.sv
// Settle-time down-counter: loads SETTLE, counts down while enabled, flags its last cycle.
module settle_timer #(
  parameter int CNT_W  = 1,
  parameter int SETTLE = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_last
);

  logic [CNT_W-1:0] r_count;

  // Count register; stops at zero so a stray decrement cannot wrap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= CNT_W'(SETTLE);
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1'b1);
    end
  end

  // The current cycle is the final settle cycle once the count is down to one.
  assign o_last = (r_count <= CNT_W'(1'b1));

endmodule

// File: rtl/gate_tt_sequencer.sv
// Sweeps every input vector of a gate under test, compares against a latched truth table.
module gate_tt_sequencer
  import gate_seq_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [2**N_IN-1:0]   i_exp_tt,
  input  logic                 i_gate_out,
  output logic [N_IN-1:0]      o_gate_in,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_pass,
  output logic [N_IN:0]        o_err_count,
  output logic [N_IN-1:0]      o_first_fail_vec,
  output logic                 o_first_fail_valid
);

  localparam int L_NVEC  = nvec(N_IN);
  localparam int L_CNT_W = cnt_w(SETTLE);

  state_t              r_state,  w_state_nx;
  logic [L_NVEC-1:0]   r_exp,    w_exp_nx;
  logic [N_IN-1:0]     r_vec,    w_vec_nx;
  logic                r_busy,   w_busy_nx;
  logic                r_done,   w_done_nx;
  logic                r_pass,   w_pass_nx;
  logic [N_IN:0]       r_err,    w_err_nx;
  logic [N_IN-1:0]     r_ffv,    w_ffv_nx;
  logic                r_ffvld,  w_ffvld_nx;
  logic                w_load;
  logic                w_dec;
  logic                w_last;
  logic                w_mismatch;

  settle_timer #(
    .CNT_W  (L_CNT_W),
    .SETTLE (SETTLE)
  ) u_timer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_load),
    .i_dec  (w_dec),
    .o_last (w_last)
  );

  assign w_mismatch = (i_gate_out != r_exp[r_vec]);

  // State and all registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_exp   <= '0;
      r_vec   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= '0;
      r_ffv   <= '0;
      r_ffvld <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_exp   <= w_exp_nx;
      r_vec   <= w_vec_nx;
      r_busy  <= w_busy_nx;
      r_done  <= w_done_nx;
      r_pass  <= w_pass_nx;
      r_err   <= w_err_nx;
      r_ffv   <= w_ffv_nx;
      r_ffvld <= w_ffvld_nx;
    end
  end

  // Next-state and next-output logic; vec is zeroed whenever the sweep is not running.
  always_comb begin
    w_state_nx = r_state;
    w_exp_nx   = r_exp;
    w_vec_nx   = r_vec;
    w_busy_nx  = r_busy;
    w_done_nx  = 1'b0;
    w_pass_nx  = r_pass;
    w_err_nx   = r_err;
    w_ffv_nx   = r_ffv;
    w_ffvld_nx = r_ffvld;
    w_load     = 1'b0;
    w_dec      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start && !i_abort) begin
          w_exp_nx   = i_exp_tt;
          w_vec_nx   = '0;
          w_err_nx   = '0;
          w_ffv_nx   = '0;
          w_ffvld_nx = 1'b0;
          w_pass_nx  = 1'b0;
          w_busy_nx  = 1'b1;
          w_load     = 1'b1;
          w_state_nx = ST_WAIT;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (i_abort) begin
          w_vec_nx   = '0;
          w_busy_nx  = 1'b0;
          w_state_nx = ST_IDLE;
        end else begin
          w_dec      = 1'b1;
          w_state_nx = w_last ? ST_SAMPLE : ST_WAIT;
        end
      end
      ST_SAMPLE: begin
        if (i_abort) begin
          w_vec_nx   = '0;
          w_busy_nx  = 1'b0;
          w_state_nx = ST_IDLE;
        end else begin
          if (w_mismatch) begin
            w_err_nx = r_err + (N_IN + 1)'(1'b1);
            if (!r_ffvld) begin
              w_ffv_nx   = r_vec;
              w_ffvld_nx = 1'b1;
            end else begin
              w_ffv_nx   = r_ffv;
            end
          end else begin
            w_err_nx = r_err;
          end
          if (&r_vec) begin
            w_vec_nx   = '0;
            w_busy_nx  = 1'b0;
            w_done_nx  = 1'b1;
            w_pass_nx  = (w_err_nx == '0);
            w_state_nx = ST_DONE;
          end else begin
            w_vec_nx   = r_vec + N_IN'(1'b1);
            w_load     = 1'b1;
            w_state_nx = ST_WAIT;
          end
        end
      end
      ST_DONE: begin
        w_state_nx = ST_IDLE;
      end
      default: begin
        w_vec_nx   = '0;
        w_busy_nx  = 1'b0;
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  assign o_gate_in          = r_vec;
  assign o_busy             = r_busy;
  assign o_done             = r_done;
  assign o_pass             = r_pass;
  assign o_err_count        = r_err;
  assign o_first_fail_vec   = r_ffv;
  assign o_first_fail_valid = r_ffvld;

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Scoreboard bench: two sequencers (SETTLE=1 and SETTLE=3) each checking a modelled 2-input gate.
module tb_gate_tt_sequencer;
  import gate_seq_pkg::*;

  typedef struct {
    logic [2:0] err;
    logic [1:0] ffv;
    logic       ffvld;
    logic       pass;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, abort, start_b, abort_b;
  logic [3:0] exp_tt, exp_b;
  logic       gate_out, gate_out_b;
  logic [1:0] gate_in, gate_in_b, ffv, ffv_b;
  logic       busy, done, pass, ffvld, busy_b, done_b, pass_b, ffvld_b;
  logic [2:0] err, err_b;
  int         gsel;

  int   n_cmp = 0;
  int   n_bad = 0;
  res_t sb[$];
  logic [1:0] obs_gi [64];
  logic       obs_busy [64];

  function automatic logic gate_fn(input int g, input logic [1:0] x);
    case (g)
      0:       return &x;
      1:       return |x;
      2:       return ^x;
      default: return ~&x;
    endcase
  endfunction

  function automatic res_t model(input int g, input logic [3:0] e);
    res_t r;
    r.err = 3'd0; r.ffv = 2'd0; r.ffvld = 1'b0;
    for (int v = 0; v < 4; v++) begin
      logic [1:0] vv;
      vv = v[1:0];
      if (gate_fn(g, vv) !== e[v]) begin
        r.err = r.err + 3'd1;
        if (!r.ffvld) begin r.ffv = vv; r.ffvld = 1'b1; end
      end
    end
    r.pass = (r.err == 3'd0);
    return r;
  endfunction

  assign gate_out   = gate_fn(gsel, gate_in);
  assign gate_out_b = gate_fn(0, gate_in_b);

  gate_tt_sequencer #(.N_IN(2), .SETTLE(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort), .i_exp_tt(exp_tt),
    .i_gate_out(gate_out), .o_gate_in(gate_in), .o_busy(busy), .o_done(done),
    .o_pass(pass), .o_err_count(err), .o_first_fail_vec(ffv), .o_first_fail_valid(ffvld)
  );

  gate_tt_sequencer #(.N_IN(2), .SETTLE(3)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_abort(abort_b), .i_exp_tt(exp_b),
    .i_gate_out(gate_out_b), .o_gate_in(gate_in_b), .o_busy(busy_b), .o_done(done_b),
    .o_pass(pass_b), .o_err_count(err_b), .o_first_fail_vec(ffv_b), .o_first_fail_valid(ffvld_b)
  );

  // Starts a sweep on instance sel, records gate_in/busy each cycle until done (bounded).
  task automatic do_sweep(input bit sel, input logic [3:0] e, input int bump_at, output int lat);
    @(negedge clk);
    if (sel) begin exp_b = e; start_b = 1'b1; end
    else begin exp_tt = e; start = 1'b1; end
    @(negedge clk);
    start = 1'b0; start_b = 1'b0;
    lat = -1;
    for (int n = 0; n < 64; n++) begin
      obs_gi[n]   = sel ? gate_in_b : gate_in;
      obs_busy[n] = sel ? busy_b : busy;
      if (sel ? done_b : done) begin lat = n; break; end
      if (n == bump_at) begin exp_tt = 4'b0000; start = 1'b1; end
      else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if ({busy, done, pass, ffvld} !== 4'b0000) begin n_bad++;
      $display("FAIL reset_flags got %b want 0000", {busy, done, pass, ffvld}); end
    n_cmp++; if (gate_in !== 2'd0) begin n_bad++; $display("FAIL reset_gate_in got %0d want 0", gate_in); end
    n_cmp++; if (err !== 3'd0) begin n_bad++; $display("FAIL reset_err got %0d want 0", err); end
    n_cmp++; if (ffv !== 2'd0) begin n_bad++; $display("FAIL reset_ffv got %0d want 0", ffv); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    n_cmp++; if ({busy_b, done_b, pass_b, err_b, gate_in_b} !== 8'd0) begin n_bad++;
      $display("FAIL reset_b got %b want 0", {busy_b, done_b, pass_b, err_b, gate_in_b}); end
  endtask

  // Runs one full sweep on instance A and scores timing, trace and results.
  task automatic test_sweep(input string nm, input int g, input logic [3:0] e, input int bump_at);
    int lat;
    res_t ex;
    gsel = g;
    sb.push_back(model(g, e));
    do_sweep(1'b0, e, bump_at, lat);
    n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL %s_latency got %0d want 8", nm, lat); end
    if (lat == 8) begin
      for (int n = 0; n <= 8; n++) begin
        logic [1:0] egi;
        egi = (n < 8) ? 2'(n / 2) : 2'd0;
        n_cmp++; if (obs_gi[n] !== egi) begin n_bad++;
          $display("FAIL %s_gate_in[%0d] got %0d want %0d", nm, n, obs_gi[n], egi); end
        n_cmp++; if (obs_busy[n] !== (n < 8)) begin n_bad++;
          $display("FAIL %s_busy[%0d] got %b want %b", nm, n, obs_busy[n], (n < 8)); end
      end
    end
    ex = sb.pop_front();
    n_cmp++; if (err !== ex.err) begin n_bad++; $display("FAIL %s_err got %0d want %0d", nm, err, ex.err); end
    n_cmp++; if (ffvld !== ex.ffvld) begin n_bad++; $display("FAIL %s_ffvld got %b want %b", nm, ffvld, ex.ffvld); end
    n_cmp++; if (ffv !== ex.ffv) begin n_bad++; $display("FAIL %s_ffv got %0d want %0d", nm, ffv, ex.ffv); end
    n_cmp++; if (pass !== ex.pass) begin n_bad++; $display("FAIL %s_pass got %b want %b", nm, pass, ex.pass); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL %s_done_width got %b want 0", nm, done); end
    n_cmp++; if (err !== ex.err) begin n_bad++; $display("FAIL %s_err_hold got %0d want %0d", nm, err, ex.err); end
  endtask

  task automatic test_abort();
    int seen;
    int found;
    gsel = 0;
    @(negedge clk); exp_tt = TT_AND2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 0;
    for (int n = 0; n < 40; n++) begin
      if (gate_in == 2'd2) begin found = 1; break; end
      @(negedge clk);
    end
    n_cmp++; if (found != 1) begin n_bad++; $display("FAIL abort_reach_vec2 got %0d want 1", found); end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    n_cmp++; if ({busy, gate_in} !== 3'b000) begin n_bad++;
      $display("FAIL abort_stop got busy=%b gate_in=%0d want 0/0", busy, gate_in); end
    seen = 0;
    repeat (12) begin if (done) seen++; @(negedge clk); end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL abort_no_done got %0d pulses want 0", seen); end
    n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL abort_pass got %b want 0", pass); end
    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL start_abort_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_abort_sample();
    int found;
    gsel = 1;
    @(negedge clk); exp_tt = TT_AND2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 0;
    for (int n = 0; n < 40; n++) begin
      if (gate_in == 2'd1) begin found = 1; break; end
      @(negedge clk);
    end
    n_cmp++; if (found != 1) begin n_bad++; $display("FAIL abs_reach_vec1 got %0d want 1", found); end
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    n_cmp++; if ({busy, err, ffvld} !== 5'b0) begin n_bad++;
      $display("FAIL abort_sample got busy=%b err=%0d ffvld=%b want 0/0/0", busy, err, ffvld); end
  endtask

  task automatic test_settle3_and_rst();
    int lat;
    int found;
    res_t ex;
    sb.push_back(model(0, TT_AND2));
    do_sweep(1'b1, TT_AND2, -1, lat);
    n_cmp++; if (lat !== 16) begin n_bad++; $display("FAIL s3_latency got %0d want 16", lat); end
    if (lat == 16) begin
      for (int n = 0; n < 16; n++) begin
        n_cmp++; if (obs_gi[n] !== 2'(n / 4)) begin n_bad++;
          $display("FAIL s3_gate_in[%0d] got %0d want %0d", n, obs_gi[n], n / 4); end
      end
    end
    ex = sb.pop_front();
    n_cmp++; if ({pass_b, err_b, ffvld_b} !== {ex.pass, ex.err, ex.ffvld}) begin n_bad++;
      $display("FAIL s3_result got %b want %b", {pass_b, err_b, ffvld_b}, {ex.pass, ex.err, ex.ffvld}); end
    // NAND table against an AND gate: vectors 0 and 1 both mismatch before vec 2
    @(negedge clk); exp_b = TT_NAND2; start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    found = 0;
    for (int n = 0; n < 80; n++) begin
      if (gate_in_b == 2'd2) begin found = 1; break; end
      @(negedge clk);
    end
    n_cmp++; if (found != 1 || err_b !== 3'd2) begin n_bad++;
      $display("FAIL s3_partial got found=%0d err=%0d want 1/2", found, err_b); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({busy_b, gate_in_b, err_b, pass_b, ffvld_b} !== 8'd0) begin n_bad++;
      $display("FAIL async_rst got %b want 0", {busy_b, gate_in_b, err_b, pass_b, ffvld_b}); end
    @(negedge clk); rst = 1'b0;
    found = 0;
    repeat (20) begin if (done_b || busy_b) found++; @(negedge clk); end
    n_cmp++; if (found != 0) begin n_bad++; $display("FAIL rst_no_done got %0d want 0", found); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    exp_tt = 4'b0000; exp_b = 4'b0000; gsel = 0;
    test_reset();
    test_sweep("and_pass", 0, TT_AND2, -1);
    test_sweep("or_vs_and", 1, TT_AND2, -1);
    test_sweep("and_vs_nand", 0, TT_NAND2, -1);
    test_sweep("xor_pass", 2, TT_XOR2, -1);
    test_abort();
    test_sweep("after_abort", 0, TT_AND2, -1);
    test_abort_sample();
    test_sweep("start_busy", 0, TT_AND2, 2);
    test_settle3_and_rst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
